// File: rtl/AESDefinitions.sv
// Shared AES-128 types, FSM encoding and GF(2^8) helpers for the iterative inverse cipher.
// S-boxes are computed as GF inverse plus affine map rather than stored tables.
package AESDefinitions;

   typedef logic [127:0] state_t;
   typedef logic [127:0] key_t;

   localparam int NUM_ROUNDS = 10;

   typedef enum logic [2:0] {IDLE, EXPAND, ADD, ROUND, DONE} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      logic [7:0] t;
      t = b ^ 8'h1b;
      return b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse; 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic key_t key_step_fwd(input key_t k, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcon, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Byte n = row + 4*col sits at bits [127-8n -: 8].
   function automatic state_t inv_shift_sub(input state_t s);
      state_t o;
      o = '0;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
      return o;
   endfunction

   function automatic state_t inv_mix_columns(input state_t s);
      state_t o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
         o[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
         o[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
         o[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward AES-128 key-schedule step: recovers k_r from k_{r+1} and the rcon used to make it.
module aes_inv_key_step
   import AESDefinitions::*;
(
   input  key_t       key_next,
   input  logic [7:0] rcon,
   output key_t       key_prev
);

   logic [31:0] w0, w1, w2, w3;

   assign w3 = key_next[31:0]  ^ key_next[63:32];
   assign w2 = key_next[63:32] ^ key_next[95:64];
   assign w1 = key_next[95:64] ^ key_next[127:96];
   assign w0 = key_next[127:96] ^ sub_rot_word(w3) ^ {rcon, 24'h0};

   assign key_prev = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one shared inverse round, on-the-fly inverse key schedule,
// and a cache of the last expanded round-10 key so repeated keys skip forward expansion.
module aes_decrypt_iter #(
   parameter int NUM_ROUNDS = AESDefinitions::NUM_ROUNDS,
   parameter int KEY_CACHE  = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  AESDefinitions::state_t  in,
   input  AESDefinitions::key_t    key,
   output logic                    out_valid,
   input  logic                    out_ready,
   output AESDefinitions::state_t  out
);
   import AESDefinitions::*;

   if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_decrypt_iter supports NUM_ROUNDS=10 only");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   fsm_t       fsm;
   state_t     st;
   key_t       kw;
   key_t       key_saved;
   key_t       cached_key;
   key_t       cached_k10;
   logic       cache_valid;
   logic [3:0] round;
   logic [7:0] rcon;

   key_t       kw_fwd;
   key_t       k_round;
   state_t     st_keyed;
   logic       cache_hit;

   assign kw_fwd    = key_step_fwd(kw, rcon);
   assign st_keyed  = inv_shift_sub(st) ^ k_round;
   assign cache_hit = (KEY_CACHE != 0) && cache_valid && (key == cached_key);

   aes_inv_key_step u_key_step (
      .key_next (kw),
      .rcon     (rcon),
      .key_prev (k_round)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm         <= IDLE;
         st          <= '0;
         kw          <= '0;
         key_saved   <= '0;
         cached_key  <= '0;
         cached_k10  <= '0;
         cache_valid <= 1'b0;
         round       <= '0;
         rcon        <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out         <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  st        <= in;
                  key_saved <= key;
                  in_ready  <= 1'b0;
                  if (cache_hit) begin
                     kw  <= cached_k10;
                     fsm <= ADD;
                  end else begin
                     kw    <= key;
                     rcon  <= 8'h01;
                     round <= '0;
                     fsm   <= EXPAND;
                  end
               end
            end
            EXPAND: begin
               kw    <= kw_fwd;
               rcon  <= xtime(rcon);
               round <= round + 4'd1;
               if (round == LAST_ROUND) begin
                  cached_k10  <= kw_fwd;
                  cached_key  <= key_saved;
                  cache_valid <= 1'b1;
                  fsm         <= ADD;
               end
            end
            ADD: begin
               st    <= st ^ kw;
               round <= LAST_ROUND;
               rcon  <= 8'h36;
               fsm   <= ROUND;
            end
            ROUND: begin
               // kw walks k10 -> k0 in lockstep with the state; rcon retraces the forward sequence.
               kw   <= k_round;
               rcon <= inv_xtime(rcon);
               if (round == 4'd0) begin
                  st        <= st_keyed;
                  out       <= st_keyed;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  st    <= inv_mix_columns(st_keyed);
                  round <= round - 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter using FIPS-197 vectors, with a second core built without the key cache.
module tb_aes_decrypt_iter;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam int unsigned LAT_MISS = 22;
   localparam int unsigned LAT_HIT  = 12;

   typedef struct {
      logic [127:0] pt;
      int unsigned  lat;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [127:0] din;
   logic [127:0] key;
   logic         out_ready;
   logic         use_nc;

   logic         m_in_valid, m_in_ready, m_out_valid;
   logic [127:0] m_out;
   logic         n_in_valid, n_in_ready, n_out_valid;
   logic [127:0] n_out;
   logic         obs_in_ready, obs_out_valid;
   logic [127:0] obs_out;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   assign m_in_valid    = in_valid & ~use_nc;
   assign n_in_valid    = in_valid & use_nc;
   assign obs_in_ready  = use_nc ? n_in_ready  : m_in_ready;
   assign obs_out_valid = use_nc ? n_out_valid : m_out_valid;
   assign obs_out       = use_nc ? n_out       : m_out;

   aes_decrypt_iter #(.NUM_ROUNDS(10), .KEY_CACHE(1)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (m_in_valid),
      .in_ready  (m_in_ready),
      .in        (din),
      .key       (key),
      .out_valid (m_out_valid),
      .out_ready (out_ready),
      .out       (m_out)
   );

   aes_decrypt_iter #(.NUM_ROUNDS(10), .KEY_CACHE(0)) dut_nc (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (n_in_valid),
      .in_ready  (n_in_ready),
      .in        (din),
      .key       (key),
      .out_valid (n_out_valid),
      .out_ready (out_ready),
      .out       (n_out)
   );

   task automatic push_exp(input logic [127:0] pt, input int unsigned lat);
      exp_t e;
      e.pt  = pt;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Presents one block once the core is idle; returns at #1 after the accept edge.
   task automatic send(input logic [127:0] ct, input logic [127:0] k, output longint t_acc);
      int unsigned n = 0;
      while (!obs_in_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      din      = ct;
      key      = k;
      in_valid = 1'b1;
      @(posedge clock);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int unsigned start, output int unsigned lat, output bit timed_out);
      lat = start;
      while (!obs_out_valid && lat < 200) begin
         @(posedge clock); #1;
         lat++;
      end
      timed_out = !obs_out_valid;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_nc = 1'b0;
      din = '0; key = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", m_in_ready); end
      checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", m_out_valid); end
      checks++; if (m_out !== 128'h0) begin failures++; $display("FAIL reset_out: got %h expected 0", m_out); end
      checks++; if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0) begin failures++; $display("FAIL reset_nc: got ready=%b valid=%b expected 1/0", n_in_ready, n_out_valid); end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_fips_c1();
      longint t; int unsigned lat; bit to; exp_t e;
      push_exp(PT_C1, LAT_MISS);
      send(CT_C1, K_C1, t);
      wait_out(1, lat, to);
      e = sb.pop_front();
      checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL c1_plaintext: got %h expected %h", obs_out, e.pt); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL c1_latency: got %0d expected %0d", lat, e.lat); end
      release_out();
      checks++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin failures++; $display("FAIL c1_release: got valid=%b ready=%b expected 0/1", m_out_valid, m_in_ready); end
      checks++; if (m_out !== PT_C1) begin failures++; $display("FAIL c1_out_retained: got %h expected %h", m_out, PT_C1); end
   endtask

   task automatic test_cache_hit();
      longint t; int unsigned lat; bit to; exp_t e;
      for (int unsigned i = 0; i < 2; i++) begin
         push_exp(PT_B, (i == 0) ? LAT_MISS : LAT_HIT);
         send(CT_B, K_B, t);
         wait_out(1, lat, to);
         e = sb.pop_front();
         checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL b_plaintext[%0d]: got %h expected %h", i, obs_out, e.pt); end
         checks++; if (lat !== e.lat) begin failures++; $display("FAIL b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      longint t, t_prev; int unsigned lat; bit to; exp_t e;
      t_prev = 0;
      out_ready = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            push_exp(PT_C1, LAT_MISS);
            send(CT_C1, K_C1, t);
         end else begin
            push_exp(PT_B, LAT_MISS);
            send(CT_B, K_B, t);
         end
         wait_out(1, lat, to);
         e = sb.pop_front();
         checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL b2b_plaintext[%0d]: got %h expected %h", i, obs_out, e.pt); end
         checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
         if (i > 0) begin
            checks++; if (t - t_prev != 230) begin failures++; $display("FAIL b2b_period[%0d]: got %0d ns expected 230 ns", i, t - t_prev); end
         end
         t_prev = t;
      end
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_no_cache();
      longint t; int unsigned lat; bit to; exp_t e;
      use_nc = 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
         push_exp(PT_B, LAT_MISS);
         send(CT_B, K_B, t);
         wait_out(1, lat, to);
         e = sb.pop_front();
         checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL nocache_plaintext[%0d]: got %h expected %h", i, obs_out, e.pt); end
         checks++; if (lat !== e.lat) begin failures++; $display("FAIL nocache_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
         release_out();
      end
      use_nc = 1'b0;
   endtask

   task automatic test_backpressure();
      longint t; int unsigned lat; bit to; exp_t e;
      push_exp(PT_C1, LAT_MISS);
      send(CT_C1, K_C1, t);
      wait_out(1, lat, to);
      e = sb.pop_front();
      checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL bp_plaintext: got %h expected %h", obs_out, e.pt); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, e.lat); end
      for (int unsigned i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         checks++;
         if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_out !== PT_C1) begin
            failures++;
            $display("FAIL bp_stall[%0d]: got valid=%b ready=%b out=%h expected 1/0/%h", i, m_out_valid, m_in_ready, m_out, PT_C1);
         end
      end
      release_out();
      checks++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", m_out_valid, m_in_ready); end
   endtask

   task automatic test_reset_mid();
      longint t; int unsigned lat; bit to; exp_t e;
      send(CT_C1, K_C1, t);
      repeat (4) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", m_in_ready); end
      checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", m_out_valid); end
      checks++; if (m_out !== 128'h0) begin failures++; $display("FAIL midrst_out: got %h expected 0", m_out); end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      push_exp(PT_C1, LAT_MISS);
      send(CT_C1, K_C1, t);
      wait_out(1, lat, to);
      e = sb.pop_front();
      checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL midrst_plaintext: got %h expected %h", obs_out, e.pt); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL midrst_latency: got %0d expected %0d", lat, e.lat); end
      release_out();
   endtask

   task automatic test_busy_ignored();
      longint t; int unsigned lat; bit to; exp_t e;
      push_exp(PT_B, LAT_MISS);
      send(CT_B, K_B, t);
      for (int unsigned i = 0; i < 6; i++) begin
         din      = {$urandom, $urandom, $urandom, $urandom};
         key      = {$urandom, $urandom, $urandom, $urandom};
         in_valid = 1'b1;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      wait_out(7, lat, to);
      e = sb.pop_front();
      checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL busy_plaintext: got %h expected %h", obs_out, e.pt); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL busy_latency: got %0d expected %0d", lat, e.lat); end
      release_out();
      push_exp(PT_B, LAT_HIT);
      send(CT_B, K_B, t);
      wait_out(1, lat, to);
      e = sb.pop_front();
      checks++; if (to || obs_out !== e.pt) begin failures++; $display("FAIL busy_followup_plaintext: got %h expected %h", obs_out, e.pt); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL busy_followup_latency: got %0d expected %0d", lat, e.lat); end
      release_out();
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_cache_hit();
      test_back_to_back();
      test_no_cache();
      test_backpressure();
      test_reset_mid();
      test_busy_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
